// File: rtl/axil_timer_slave.sv
// AXI4-Lite slave around a 32-bit up-counter with compare match, auto-reload,
// a W1C match flag and a registered level interrupt.
module axil_timer_slave #(
  parameter int          ADDR_W        = 32,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [ADDR_W-1:0] axi_slave1_awaddr,
  input  logic [2:0]        axi_slave1_awprot,
  input  logic              axi_slave1_awvalid,
  output logic              axi_slave1_awready,
  input  logic [31:0]       axi_slave1_wdata,
  input  logic [3:0]        axi_slave1_wstrb,
  input  logic              axi_slave1_wvalid,
  output logic              axi_slave1_wready,
  output logic [1:0]        axi_slave1_bresp,
  output logic              axi_slave1_bvalid,
  input  logic              axi_slave1_bready,
  input  logic [ADDR_W-1:0] axi_slave1_araddr,
  input  logic [2:0]        axi_slave1_arprot,
  input  logic              axi_slave1_arvalid,
  output logic              axi_slave1_arready,
  output logic [31:0]       axi_slave1_rdata,
  output logic [1:0]        axi_slave1_rresp,
  output logic              axi_slave1_rvalid,
  input  logic              axi_slave1_rready,
  output logic              axi_interrupt1
);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_CMP  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  wr_req_t     wreq;
  logic        bus_live;
  logic        wr_hs, rd_hs;
  logic [2:0]  ctrl;
  logic [31:0] cmp, cnt, rdata_q, rd_view, wr_view, wr_merged;
  logic        match, irq_q, match_hit, en, irq_en, auto_rl;
  logic        unused_ok;

  assign unused_ok = ^{axi_slave1_awprot, axi_slave1_arprot,
                       axi_slave1_awaddr[ADDR_W-1:4], axi_slave1_awaddr[1:0],
                       axi_slave1_araddr[ADDR_W-1:4], axi_slave1_araddr[1:0]};

  function automatic logic [31:0] reg_view(input logic [1:0] sel, input logic [2:0] c,
                                           input logic [31:0] cp, input logic [31:0] cn,
                                           input logic m);
    logic [31:0] v;
    case (sel)
      A_CTRL:  v = {29'b0, c};
      A_CMP:   v = cp;
      A_CNT:   v = cn;
      default: v = {31'b0, m};
    endcase
    return v;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  // Keeps handshakes quiet while reset is held, even if a master drives valid.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) bus_live <= 1'b0;
    else              bus_live <= 1'b1;
  end

  assign wreq = '{sel: axi_slave1_awaddr[3:2], data: axi_slave1_wdata, strb: axi_slave1_wstrb};

  // ---------------- write channel ----------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    wr_hs  = 1'b0;
    case (w_state)
      W_IDLE: if (bus_live && axi_slave1_awvalid && axi_slave1_wvalid) begin
        wr_hs  = 1'b1;
        w_next = W_RESP;
      end
      W_RESP: if (axi_slave1_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign axi_slave1_awready = wr_hs;
  assign axi_slave1_wready  = wr_hs;
  assign axi_slave1_bvalid  = (w_state == W_RESP);
  assign axi_slave1_bresp   = 2'b00;

  // ---------------- read channel ----------------
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    rd_hs  = 1'b0;
    case (r_state)
      R_IDLE: if (bus_live && axi_slave1_arvalid) begin
        rd_hs  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: if (axi_slave1_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign rd_view = reg_view(axi_slave1_araddr[3:2], ctrl, cmp, cnt, match);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  rdata_q <= '0;
    else if (rd_hs)    rdata_q <= rd_view;
  end

  assign axi_slave1_arready = rd_hs;
  assign axi_slave1_rvalid  = (r_state == R_DATA);
  assign axi_slave1_rresp   = 2'b00;
  assign axi_slave1_rdata   = rdata_q;

  // ---------------- timer core ----------------
  assign en        = ctrl[0];
  assign irq_en    = ctrl[1];
  assign auto_rl   = ctrl[2];
  assign match_hit = en && (cnt == cmp);
  assign wr_view   = reg_view(wreq.sel, ctrl, cmp, cnt, match);
  assign wr_merged = byte_merge(wr_view, wreq.data, wreq.strb);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ctrl  <= '0;
      cmp   <= RESET_COMPARE;
      cnt   <= '0;
      match <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_hs && wreq.sel == A_CTRL) ctrl <= wr_merged[2:0];
      if (wr_hs && wreq.sel == A_CMP)  cmp  <= wr_merged;
      // A bus write to COUNT overrides both increment and reload.
      if (wr_hs && wreq.sel == A_CNT)  cnt  <= wr_merged;
      else if (en)                     cnt  <= (match_hit && auto_rl) ? 32'd0 : cnt + 32'd1;
      // Set beats a coincident W1C clear.
      if (match_hit)
        match <= 1'b1;
      else if (wr_hs && wreq.sel == A_STAT && wreq.strb[0] && wreq.data[0])
        match <= 1'b0;
      irq_q <= match && irq_en;
    end
  end

  assign axi_interrupt1 = irq_q;

endmodule

// File: tb/tb_axil_timer_slave.sv
// Self-checking bench for axil_timer_slave: register vectors, random register
// traffic against an array model, timer arithmetic and bus corner sequences.
module tb_axil_timer_slave;
  localparam logic [31:0] RC = 32'hFFFF_FFFF;

  logic        axi_aclk = 1'b0, axi_aresetn;
  logic [31:0] axi_slave1_awaddr, axi_slave1_araddr, axi_slave1_wdata, axi_slave1_rdata;
  logic [2:0]  axi_slave1_awprot, axi_slave1_arprot;
  logic [3:0]  axi_slave1_wstrb;
  logic [1:0]  axi_slave1_bresp, axi_slave1_rresp;
  logic        axi_slave1_awvalid, axi_slave1_awready, axi_slave1_wvalid, axi_slave1_wready;
  logic        axi_slave1_bvalid, axi_slave1_bready, axi_slave1_arvalid, axi_slave1_arready;
  logic        axi_slave1_rvalid, axi_slave1_rready, axi_interrupt1;

  axil_timer_slave #(.ADDR_W(32), .RESET_COMPARE(RC)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .axi_slave1_awaddr(axi_slave1_awaddr), .axi_slave1_awprot(axi_slave1_awprot),
    .axi_slave1_awvalid(axi_slave1_awvalid), .axi_slave1_awready(axi_slave1_awready),
    .axi_slave1_wdata(axi_slave1_wdata), .axi_slave1_wstrb(axi_slave1_wstrb),
    .axi_slave1_wvalid(axi_slave1_wvalid), .axi_slave1_wready(axi_slave1_wready),
    .axi_slave1_bresp(axi_slave1_bresp), .axi_slave1_bvalid(axi_slave1_bvalid),
    .axi_slave1_bready(axi_slave1_bready),
    .axi_slave1_araddr(axi_slave1_araddr), .axi_slave1_arprot(axi_slave1_arprot),
    .axi_slave1_arvalid(axi_slave1_arvalid), .axi_slave1_arready(axi_slave1_arready),
    .axi_slave1_rdata(axi_slave1_rdata), .axi_slave1_rresp(axi_slave1_rresp),
    .axi_slave1_rvalid(axi_slave1_rvalid), .axi_slave1_rready(axi_slave1_rready),
    .axi_interrupt1(axi_interrupt1)
  );

  always #5 axi_aclk = ~axi_aclk;

  int cyc = 0;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++; n_bad++;
    $display("FAIL %s: timed out waiting for handshake (cycle %0d)", nm, cyc);
  endtask

  // Handshake lands on the first rising edge after the call; hs = that edge's index.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int hs);
    int n;
    hs = -1;
    @(negedge axi_aclk);
    axi_slave1_awaddr = a; axi_slave1_wdata = d; axi_slave1_wstrb = s;
    axi_slave1_awvalid = 1'b1; axi_slave1_wvalid = 1'b1;
    #1 n = 0;
    while (!(axi_slave1_awready && axi_slave1_wready) && n < 40) begin
      @(negedge axi_aclk); #1 n++;
    end
    if (n >= 40) begin
      tmo("aw_w_ready"); axi_slave1_awvalid = 1'b0; axi_slave1_wvalid = 1'b0; return;
    end
    @(posedge axi_aclk); #1 hs = cyc;
    axi_slave1_awvalid = 1'b0; axi_slave1_wvalid = 1'b0; axi_slave1_bready = 1'b1;
    n = 0;
    while (!axi_slave1_bvalid && n < 40) begin @(posedge axi_aclk); #1 n++; end
    if (n >= 40) begin tmo("bvalid"); axi_slave1_bready = 1'b0; return; end
    chk("bresp", {30'b0, axi_slave1_bresp}, 32'd0);
    @(posedge axi_aclk); #1 axi_slave1_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output int cap);
    int n;
    d = 'x; cap = -1;
    @(negedge axi_aclk);
    axi_slave1_araddr = a; axi_slave1_arvalid = 1'b1;
    #1 n = 0;
    while (!axi_slave1_arready && n < 40) begin @(negedge axi_aclk); #1 n++; end
    if (n >= 40) begin tmo("arready"); axi_slave1_arvalid = 1'b0; return; end
    @(posedge axi_aclk); #1 cap = cyc;
    axi_slave1_arvalid = 1'b0; axi_slave1_rready = 1'b1;
    n = 0;
    while (!axi_slave1_rvalid && n < 40) begin @(posedge axi_aclk); #1 n++; end
    if (n >= 40) begin tmo("rvalid"); axi_slave1_rready = 1'b0; return; end
    d = axi_slave1_rdata;
    chk("rresp", {30'b0, axi_slave1_rresp}, 32'd0);
    @(posedge axi_aclk); #1 axi_slave1_rready = 1'b0;
  endtask

  // Idle until the next call's handshake will land exactly on edge t.
  task automatic align_to(input int t);
    if (cyc > t - 1) begin tmo("align"); return; end
    while (cyc < t - 1) begin @(posedge axi_aclk); #1; end
  endtask

  function automatic int next_phase(input int e0, input int per, input int ph, input int after);
    int t = after + 1;
    while (((t - e0) % per) != ph) t++;
    return t;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] mreg[4];
  logic [31:0] rd, d, start;
  int          hs, cap, e0, t, n;
  logic        stray, ok;

  initial begin
    tbl[0] = '{32'h4, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
    tbl[1] = '{32'h4, 32'h1122_3344, 4'h5, 32'hAA22_CC44};
    tbl[2] = '{32'h4, 32'h0000_0000, 4'h8, 32'h0022_CC44};
    tbl[3] = '{32'h0, 32'hFFFF_FFF6, 4'hF, 32'h0000_0006};
    tbl[4] = '{32'h0, 32'h0000_0001, 4'hE, 32'h0000_0006};
    tbl[5] = '{32'h0, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[6] = '{32'h8, 32'h1234_5678, 4'hC, 32'h1234_0000};
    tbl[7] = '{32'hC, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    tbl[8] = '{32'h8, 32'h0000_ABCD, 4'h3, 32'h1234_ABCD};
    tbl[9] = '{32'h4, 32'h5A5A_5A5A, 4'h0, 32'h0022_CC44};

    axi_aresetn = 1'b0;
    axi_slave1_awaddr = '0; axi_slave1_awprot = '0; axi_slave1_awvalid = 1'b0;
    axi_slave1_wdata = '0; axi_slave1_wstrb = '0; axi_slave1_wvalid = 1'b0;
    axi_slave1_bready = 1'b0; axi_slave1_araddr = '0; axi_slave1_arprot = '0;
    axi_slave1_arvalid = 1'b0; axi_slave1_rready = 1'b0;

    // Reset state
    #22;
    chk("reset_outputs", {21'b0, axi_slave1_awready, axi_slave1_wready, axi_slave1_bvalid,
        axi_slave1_bresp, axi_slave1_arready, axi_slave1_rvalid, axi_slave1_rresp,
        axi_interrupt1}, 32'd0);
    chk("reset_rdata", axi_slave1_rdata, 32'd0);
    @(negedge axi_aclk); axi_aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      axi_read(i * 4, rd, cap);
      chk($sformatf("reset_reg%0d", i), rd, (i == 1) ? RC : 32'd0);
    end

    // Vector table: write then read back
    foreach (tbl[i]) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, hs);
      axi_read(tbl[i].addr, rd, cap);
      chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // Random register traffic with the timer stopped
    mreg[3] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      if (i == 0) d = d & 32'h6;
      axi_write(i * 4, d, 4'hF, hs);
      mreg[i] = d;
    end
    for (int k = 0; k < 40; k++) begin
      int a = $urandom_range(0, 3);
      logic [3:0] s = 4'($urandom);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (a == 0) d[0] = 1'b0;
        axi_write(a * 4, d, s, hs);
        if (a != 3) mreg[a] = (mreg[a] & ~strb_mask(s)) | (d & strb_mask(s));
        if (a == 0) mreg[0] = mreg[0] & 32'h7;
      end else begin
        axi_read(a * 4, rd, cap);
        chk($sformatf("rand_rd%0d_a%0d", k, a), rd, mreg[a]);
      end
    end

    // Random timer runs: COUNT = start + edges elapsed since enable
    for (int k = 0; k < 4; k++) begin
      start = $urandom;
      axi_write(32'h0, 32'h0, 4'hF, hs);
      axi_write(32'h8, start, 4'hF, hs);
      axi_write(32'h4, start + 32'd1000, 4'hF, hs);
      axi_write(32'h0, 32'h1, 4'hF, e0);
      repeat ($urandom_range(0, 30)) @(posedge axi_aclk);
      #1 axi_read(32'h8, rd, cap);
      chk($sformatf("timer_run%0d", k), rd, start + 32'(cap - e0 - 1));
    end

    // Compare 0x10 with auto-reload and interrupt
    axi_write(32'h0, 32'h0, 4'hF, hs);
    axi_write(32'h8, 32'h0, 4'hF, hs);
    axi_write(32'h4, 32'h10, 4'hF, hs);
    axi_write(32'h0, 32'h7, 4'hF, e0);
    n = 0;
    while (!axi_interrupt1 && n < 100) begin @(posedge axi_aclk); #1 n++; end
    if (n >= 100) tmo("irq_rise");
    else chk("irq_edge", 32'(cyc), 32'(e0 + 18));
    axi_read(32'hC, rd, cap);
    chk("match_set", rd, 32'd1);
    align_to(next_phase(e0, 17, 1, cyc));
    axi_read(32'h8, rd, cap);
    chk("count_after_reload", rd, 32'd0);
    axi_read(32'h8, rd, cap);
    chk("count_periodic", rd, 32'((cap - e0 - 1) % 17));

    // W1C clear off-match, then a clear coinciding with the set
    align_to(next_phase(e0, 17, 5, cyc));
    axi_write(32'hC, 32'h1, 4'h1, hs);
    axi_read(32'hC, rd, cap);
    chk("w1c_clear", rd, 32'd0);
    chk("irq_after_clear", {31'b0, axi_interrupt1}, 32'd0);
    t = next_phase(e0, 17, 0, cyc);
    align_to(t);
    axi_write(32'hC, 32'h1, 4'h1, hs);
    chk("clear_on_match_edge", 32'(hs), 32'(t));
    axi_read(32'hC, rd, cap);
    chk("set_beats_clear", rd, 32'd1);
    chk("irq_held", {31'b0, axi_interrupt1}, 32'd1);
    axi_write(32'h0, 32'h2, 4'hF, hs);
    axi_write(32'hC, 32'h1, 4'hF, hs);
    axi_read(32'hC, rd, cap);
    chk("late_clear", rd, 32'd0);
    chk("irq_dropped", {31'b0, axi_interrupt1}, 32'd0);

    // Lone AW for 3 cycles, then B back-pressure stalling a second write
    @(negedge axi_aclk);
    axi_slave1_awaddr = 32'h4; axi_slave1_wdata = 32'hCAFE_0001; axi_slave1_wstrb = 4'hF;
    axi_slave1_awvalid = 1'b1; stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 stray |= axi_slave1_awready | axi_slave1_wready;
      @(negedge axi_aclk);
    end
    chk("lone_aw_no_ready", {31'b0, stray}, 32'd0);
    axi_slave1_wvalid = 1'b1;
    #1 chk("both_valid_ready", {30'b0, axi_slave1_awready, axi_slave1_wready}, 32'd3);
    @(posedge axi_aclk); #1 axi_slave1_wdata = 32'hBEEF_0002;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi_aclk); #1 ok &= axi_slave1_bvalid & ~axi_slave1_awready & ~axi_slave1_wready;
    end
    chk("bvalid_hold_stall", {31'b0, ok}, 32'd1);
    axi_slave1_bready = 1'b1;
    @(posedge axi_aclk); #1 n = 0;
    while (!axi_slave1_awready && n < 10) begin @(posedge axi_aclk); #1 n++; end
    if (n >= 10) tmo("second_write");
    @(posedge axi_aclk); #1 axi_slave1_awvalid = 1'b0; axi_slave1_wvalid = 1'b0;
    chk("second_bvalid", {31'b0, axi_slave1_bvalid}, 32'd1);
    @(posedge axi_aclk); #1 axi_slave1_bready = 1'b0;
    axi_read(32'h4, rd, cap);
    chk("second_write_data", rd, 32'hBEEF_0002);

    // Wrap through zero, match at 5 without reload
    axi_write(32'h0, 32'h0, 4'hF, hs);
    axi_write(32'h8, 32'hFFFF_FFFE, 4'hF, hs);
    axi_write(32'h4, 32'h5, 4'hF, hs);
    axi_write(32'h0, 32'h1, 4'hF, e0);
    axi_read(32'h8, rd, cap);
    chk("wrap_count_a", rd, 32'hFFFF_FFFE + 32'(cap - e0 - 1));
    axi_read(32'hC, rd, cap);
    chk("wrap_status_a", rd, (cap > e0 + 8) ? 32'd1 : 32'd0);
    align_to(e0 + 12);
    axi_read(32'h8, rd, cap);
    chk("wrap_count_b", rd, 32'hFFFF_FFFE + 32'(cap - e0 - 1));
    axi_read(32'hC, rd, cap);
    chk("wrap_status_b", rd, 32'd1);
    chk("wrap_no_irq", {31'b0, axi_interrupt1}, 32'd0);

    // Asynchronous reset in the middle of a read response
    @(negedge axi_aclk); axi_slave1_araddr = 32'h4; axi_slave1_arvalid = 1'b1;
    @(posedge axi_aclk); #1 axi_slave1_arvalid = 1'b0;
    chk("rvalid_before_reset", {31'b0, axi_slave1_rvalid}, 32'd1);
    #2 axi_aresetn = 1'b0;
    #1 chk("async_reset_outs", {26'b0, axi_slave1_rvalid, axi_slave1_arready,
        axi_slave1_awready, axi_slave1_wready, axi_slave1_bvalid, axi_interrupt1}, 32'd0);
    chk("async_reset_rdata", axi_slave1_rdata, 32'd0);
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk); axi_aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      axi_read(i * 4, rd, cap);
      chk($sformatf("post_reset_reg%0d", i), rd, (i == 1) ? RC : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
